// File: rtl/midi_pkg.sv
// Shared MIDI definitions for the midi_out message transmitter.
//   - channel-message codes (upper nibble of the status byte)
//   - message FSM state enumeration
//   - data_bytes(): number of data bytes that follow a given status code
package midi_pkg;

  localparam logic [3:0] NOTE_OFF      = 4'h8;
  localparam logic [3:0] NOTE_ON       = 4'h9;
  localparam logic [3:0] POLY_PRESSURE = 4'hA;
  localparam logic [3:0] CONTROL       = 4'hB;
  localparam logic [3:0] PROGRAM       = 4'hC;
  localparam logic [3:0] CHAN_PRESSURE = 4'hD;
  localparam logic [3:0] PITCH         = 4'hE;

  typedef enum logic [1:0] {
    StIdle,
    StStatus,
    StData1,
    StData2
  } midi_state_e;

  // Codes without bit 3 set are not channel messages and carry no bytes.
  function automatic logic [1:0] data_bytes(input logic [3:0] code);
    logic [1:0] n;
    n = 2'd0;
    case (code)
      PROGRAM, CHAN_PRESSURE:                         n = 2'd1;
      NOTE_OFF, NOTE_ON, POLY_PRESSURE, CONTROL, PITCH: n = 2'd2;
      default:                                        n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/midi_tx_byte.sv
// Single-byte MIDI serializer: start bit (0), 8 data bits LSB first, stop bit (1),
// each BIT_DIV clocks long.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load data; start bit appears on the next cycle (overrides any
//               frame in progress, which allows back-to-back bytes)
//   data        byte to send, sampled when start is high
//   tx          serial output, high when idle
//   done        high during the final clock of the stop bit
module midi_tx_byte #(
  parameter int unsigned BIT_DIV = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CntW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BIT_DIV - 1);

  logic [9:0]      shift_q;
  logic [3:0]      bit_q;
  logic [CntW-1:0] baud_q;
  logic            active_q;
  logic            bit_end;

  assign bit_end = (baud_q == CntLast);
  assign done    = active_q && bit_end && (bit_q == 4'd9);
  // Mux from flops: reset clears active_q asynchronously, forcing tx high at once.
  assign tx      = active_q ? shift_q[0] : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      shift_q  <= '1;
      bit_q    <= 4'd0;
      baud_q   <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      shift_q  <= {1'b1, data, 1'b0};
      bit_q    <= 4'd0;
      baud_q   <= '0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_q  <= '0;
        shift_q <= {1'b1, shift_q[9:1]};
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
        end else begin
          bit_q <= bit_q + 4'd1;
        end
      end else begin
        baud_q <= baud_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/midi_out.sv
// MIDI channel-message transmitter with optional running status.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   msg_valid/ready message handshake; fields captured on acceptance
//   ch_message      status code (8..E), chan: channel 0..15
//   data1, data2    7-bit data bytes
//   tx              MIDI serial output, idles high
//   busy            high from acceptance until the last stop bit ends
module midi_out
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned BAUD           = 31250,
  parameter int unsigned RUNNING_STATUS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [3:0] ch_message,
  input  logic [3:0] chan,
  input  logic [6:0] data1,
  input  logic [6:0] data2,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BIT_DIV = CLK_HZ / BAUD;

  midi_state_e state_q, state_d;
  logic [3:0]  code_q;
  logic [6:0]  data1_q, data2_q;
  logic [7:0]  last_status_q, last_status_d;
  logic        drop_q, drop_d;
  logic        ready_en_q;
  logic        capture;
  logic        accept;
  logic        suppress;
  logic [7:0]  new_status;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;

  assign accept     = msg_valid && msg_ready;
  assign new_status = {ch_message, chan};
  assign suppress   = (RUNNING_STATUS != 0) && (new_status == last_status_q);

  // ready_en_q holds msg_ready low until the first edge after reset release;
  // drop_q stretches busy over the single cycle of a discarded message.
  assign msg_ready = ready_en_q && (state_q == StIdle) && !drop_q;
  assign busy      = (state_q != StIdle) || drop_q;

  always_comb begin
    state_d       = state_q;
    last_status_d = last_status_q;
    drop_d        = 1'b0;
    capture       = 1'b0;
    tx_start      = 1'b0;
    tx_data       = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!ch_message[3]) begin
            drop_d = 1'b1;
          end else begin
            capture  = 1'b1;
            tx_start = 1'b1;
            if (suppress) begin
              tx_data = {1'b0, data1};
              state_d = StData1;
            end else begin
              tx_data       = new_status;
              last_status_d = new_status;
              state_d       = StStatus;
            end
          end
        end
      end
      StStatus: begin
        if (tx_done) begin
          tx_start = 1'b1;
          tx_data  = {1'b0, data1_q};
          state_d  = StData1;
        end
      end
      StData1: begin
        if (tx_done) begin
          if (data_bytes(code_q) == 2'd2) begin
            tx_start = 1'b1;
            tx_data  = {1'b0, data2_q};
            state_d  = StData2;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData2: begin
        if (tx_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_status_q <= 8'h00;
      drop_q        <= 1'b0;
      ready_en_q    <= 1'b0;
      code_q        <= 4'h0;
      data1_q       <= 7'h00;
      data2_q       <= 7'h00;
    end else begin
      state_q       <= state_d;
      last_status_q <= last_status_d;
      drop_q        <= drop_d;
      ready_en_q    <= 1'b1;
      if (capture) begin
        code_q  <= ch_message;
        data1_q <= data1;
        data2_q <= data2;
      end
    end
  end

  midi_tx_byte #(
    .BIT_DIV(BIT_DIV)
  ) u_tx_byte (
    .clk  (clk),
    .rst_n(rst_n),
    .start(tx_start),
    .data (tx_data),
    .tx   (tx),
    .done (tx_done)
  );

endmodule

// File: tb/tb_midi_out.sv
// Scoreboard bench for midi_out: stimulus pushes expected bytes into exp_q, a
// tx monitor decodes each frame cycle by cycle and compares it with the queue head.
`timescale 1ns / 1ps
module tb_midi_out;

  localparam int unsigned CLK_HZ = 500000;
  localparam int unsigned BAUD   = 31250;
  localparam int unsigned BD     = CLK_HZ / BAUD;  // 16 clocks per bit

  logic       clk = 1'b0;
  logic       rst_n;
  logic       msg_valid;
  logic       msg_ready;
  logic [3:0] ch_message;
  logic [3:0] chan;
  logic [6:0] data1;
  logic [6:0] data2;
  logic       tx;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  bit mon_active = 1'b0;

  always #5 clk = ~clk;

  midi_out #(
    .CLK_HZ        (CLK_HZ),
    .BAUD          (BAUD),
    .RUNNING_STATUS(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .ch_message(ch_message),
    .chan      (chan),
    .data1     (data1),
    .data2     (data2),
    .tx        (tx),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle of every bit must match the expected frame.
  initial begin
    logic [9:0] frame;
    logic [7:0] exp_b;
    int bit_i;
    int cnt;
    bit err;
    bit_i = 0;
    cnt = 0;
    err = 1'b0;
    frame = '1;
    exp_b = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && tx === 1'b0) begin
          mon_active = 1'b1;
          bit_i = 0;
          cnt = 0;
          err = 1'b0;
          if (exp_q.size() == 0) begin
            err = 1'b1;
            exp_b = 8'hxx;
            frame = '1;
          end else begin
            exp_b = exp_q.pop_front();
            frame = {1'b1, exp_b, 1'b0};
          end
        end
        if (mon_active) begin
          if (tx !== frame[bit_i]) err = 1'b1;
          cnt++;
          if (cnt == BD) begin
            cnt = 0;
            bit_i++;
            if (bit_i == 10) begin
              mon_active = 1'b0;
              tests++;
              if (err) begin
                fails++;
                $display("FAIL tx byte: frame differs from expected byte %0h at t=%0t",
                         exp_b, $time);
              end
            end
          end
        end
      end
    end
  end

  // Called at a negedge. Accepts one message and measures the busy window.
  task automatic send_msg(input logic [3:0] c, input logic [3:0] ch, input logic [6:0] d1,
                          input logic [6:0] d2, input int exp_busy, input bit valid_code,
                          input int hold);
    int n;
    n = 0;
    while (msg_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready before send", msg_ready, 1'b1);
    ch_message = c;
    chan = ch;
    data1 = d1;
    data2 = d2;
    msg_valid = 1'b1;
    @(posedge clk);
    #1;
    msg_valid = (hold > 0);
    ch_message = 4'($urandom);
    chan = 4'($urandom);
    data1 = 7'($urandom);
    data2 = 7'($urandom);
    @(negedge clk);
    check("busy after accept", busy, 1'b1);
    check("ready drops after accept", msg_ready, 1'b0);
    check("tx start bit timing", tx, valid_code ? 1'b0 : 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 40 * BD) begin
      n++;
      if (n >= hold) msg_valid = 1'b0;
      @(negedge clk);
    end
    msg_valid = 1'b0;
    check("busy length", n, exp_busy);
    check("ready after message", msg_ready, 1'b1);
    check("tx idle after message", tx, 1'b1);
  endtask

  initial begin
    #(500000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    msg_valid = 1'b0;
    ch_message = 4'h0;
    chan = 4'h0;
    data1 = 7'h00;
    data2 = 7'h00;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset ready", msg_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready first edge after reset", msg_ready, 1'b1);

    // Note on, full status.
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    send_msg(4'h9, 4'h0, 7'd60, 7'd100, 30 * BD, 1'b1, 0);
    // Running status, msg_valid held high while busy must be ignored.
    exp_q.push_back(8'h3E); exp_q.push_back(8'h00);
    send_msg(4'h9, 4'h0, 7'd62, 7'd0, 20 * BD, 1'b1, 50);
    // Channel change forces status.
    exp_q.push_back(8'h91); exp_q.push_back(8'h3E); exp_q.push_back(8'h00);
    send_msg(4'h9, 4'h1, 7'd62, 7'd0, 30 * BD, 1'b1, 0);
    // Program change: one data byte.
    exp_q.push_back(8'hC5); exp_q.push_back(8'h07);
    send_msg(4'hC, 4'h5, 7'd7, 7'h55, 20 * BD, 1'b1, 0);
    // Invalid code: discarded, last_status stays C5.
    send_msg(4'h3, 4'h0, 7'd1, 7'd1, 1, 1'b0, 0);
    exp_q.push_back(8'h09);
    send_msg(4'hC, 4'h5, 7'd9, 7'h2A, 10 * BD, 1'b1, 0);
    // Control change after running program changes.
    exp_q.push_back(8'hB5); exp_q.push_back(8'h07); exp_q.push_back(8'h40);
    send_msg(4'hB, 4'h5, 7'd7, 7'h40, 30 * BD, 1'b1, 0);
    // Pitch bend on channel 15.
    exp_q.push_back(8'hEF); exp_q.push_back(8'h7F); exp_q.push_back(8'h01);
    send_msg(4'hE, 4'hF, 7'h7F, 7'h01, 30 * BD, 1'b1, 0);

    // Reset mid-DATA1: establish last_status 90, then start a suppressed repeat.
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    send_msg(4'h9, 4'h0, 7'd60, 7'd100, 30 * BD, 1'b1, 0);
    exp_q.push_back(8'h3C);
    ch_message = 4'h9; chan = 4'h0; data1 = 7'd60; data2 = 7'd100;
    msg_valid = 1'b1;
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    repeat (5 * BD) @(negedge clk);
    check("busy mid DATA1", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("tx high on async reset", tx, 1'b1);
    check("busy low on reset", busy, 1'b0);
    check("ready low on reset", msg_ready, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after mid reset", msg_ready, 1'b1);
    exp_q.push_back(8'h90); exp_q.push_back(8'h3C); exp_q.push_back(8'h64);
    send_msg(4'h9, 4'h0, 7'd60, 7'd100, 30 * BD, 1'b1, 0);

    repeat (5) @(negedge clk);
    check("all expected bytes seen", exp_q.size(), 0);
    check("monitor idle at end", mon_active, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
